stack_unit: RTL

Parametrised, byte-addressed stack memory with an internal stack pointer. It replaces the word-indexed stack store, where ESP moved by one entry per 4-byte operation and the ALU had to divide by 4. It sits between the selector/ALU datapath and the register file. It serves PUSH/POP, frame-relative LOAD/STORE and ESP arithmetic through one valid/ready request port. Every operation has bounds and alignment checking and reports a sticky fault.

---
 rtl/stack_unit.sv | 223 ++++++++++++++++++++++
 1 files changed

// File: rtl/stack_unit.sv
// stack_unit
// Byte-addressed, downward-growing stack memory with an internal stack
// pointer. A single valid/ready request port carries PUSH/POP,
// frame-relative LOAD/STORE and ESP arithmetic. Every request is checked
// for bounds and alignment, and problems are reported through a sticky
// fault flag.
//
// Ports
//   clk          rising-edge clock
//   reset        asynchronous, active-high reset
//   op_valid     request present
//   op_ready     request accepted when op_valid && op_ready
//   op_code      0 NOP, 1 PUSH, 2 POP, 3 LOAD, 4 STORE, 5 ADD_ESP, 6 SET_ESP, 7 illegal
//   op_addr      byte address for LOAD/STORE/SET_ESP
//   op_data      write data (PUSH/STORE) or signed byte offset (ADD_ESP)
//   rd_valid     one-cycle pulse, rd_data valid
//   rd_data      read result, held until the next read
//   esp          current stack pointer (byte address)
//   count        words in use
//   full/empty   esp at BASE / at STACK_TOP
//   fault        sticky error flag
//   fault_code   first cause: 1 overflow, 2 underflow, 3 misaligned,
//                4 out of range, 5 illegal op
//   clear_fault  clears fault and fault_code
//
// state  | meaning
// IDLE   | ready for a request
// READ   | array being read for an accepted POP/LOAD; op_ready low
module stack_unit #(
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned DEPTH     = 256,
  parameter logic [31:0] STACK_TOP = 32'h0000_0400
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         op_valid,
  output logic                         op_ready,
  input  logic [2:0]                   op_code,
  input  logic [31:0]                  op_addr,
  input  logic [DATA_W-1:0]            op_data,
  output logic                         rd_valid,
  output logic [DATA_W-1:0]            rd_data,
  output logic [31:0]                  esp,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         full,
  output logic                         empty,
  output logic                         fault,
  output logic [2:0]                   fault_code,
  input  logic                         clear_fault
);

  localparam int unsigned BYTES   = DATA_W / 8;
  localparam int unsigned LB      = $clog2(BYTES);
  localparam int unsigned AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW      = $clog2(DEPTH + 1);
  localparam logic [31:0] BYTES32 = 32'(BYTES);
  localparam logic [31:0] BASE    = STACK_TOP - 32'(DEPTH * BYTES);
  // Wide enough to hold esp plus a sign-extended offset without wrapping.
  localparam int unsigned SW      = (DATA_W > 32) ? DATA_W + 1 : 33;

  localparam logic [2:0] OP_NOP   = 3'd0;
  localparam logic [2:0] OP_PUSH  = 3'd1;
  localparam logic [2:0] OP_POP   = 3'd2;
  localparam logic [2:0] OP_LOAD  = 3'd3;
  localparam logic [2:0] OP_STORE = 3'd4;
  localparam logic [2:0] OP_ADD   = 3'd5;
  localparam logic [2:0] OP_SET   = 3'd6;

  localparam logic [2:0] F_NONE   = 3'd0;
  localparam logic [2:0] F_OVER   = 3'd1;
  localparam logic [2:0] F_UNDER  = 3'd2;
  localparam logic [2:0] F_ALIGN  = 3'd3;
  localparam logic [2:0] F_RANGE  = 3'd4;
  localparam logic [2:0] F_ILLEG  = 3'd5;

  typedef enum logic {S_IDLE, S_READ} state_e;

  state_e              state_q, state_d;
  logic [31:0]         esp_q, esp_d;
  logic                fault_q, fault_d;
  logic [2:0]          fault_code_q, fault_code_d;
  logic [DATA_W-1:0]   rd_data_q;
  logic                rd_valid_q;
  logic [AW-1:0]       rd_idx_q, rd_idx_d;

  logic                mem_we;
  logic [AW-1:0]       mem_widx;
  logic [DATA_W-1:0]   mem [DEPTH];

  logic                addr_misal, data_misal;
  logic                addr_in_mem, addr_in_esp, add_in_range;
  logic [SW-1:0]       add_sum;
  logic [AW-1:0]       addr_idx, esp_idx, push_idx;
  logic [2:0]          req_code;

  assign addr_misal  = |op_addr[LB-1:0];
  assign data_misal  = |op_data[LB-1:0];
  assign addr_in_mem = (op_addr >= BASE) && (op_addr <  STACK_TOP);
  assign addr_in_esp = (op_addr >= BASE) && (op_addr <= STACK_TOP);

  assign add_sum = {{(SW-32){1'b0}}, esp_q} + {{(SW-DATA_W){op_data[DATA_W-1]}}, op_data};
  // A set top bit means the sum went negative, which is always out of range.
  assign add_in_range = !add_sum[SW-1] && (add_sum >= SW'(BASE)) && (add_sum <= SW'(STACK_TOP));

  assign addr_idx = AW'((op_addr - BASE) >> LB);
  assign esp_idx  = AW'((esp_q - BASE) >> LB);
  assign push_idx = AW'((esp_q - BYTES32 - BASE) >> LB);

  // Fault classification, highest priority first.
  always_comb begin
    req_code = F_NONE;
    case (op_code)
      OP_PUSH:  if (esp_q == BASE)      req_code = F_OVER;
      OP_POP:   if (esp_q == STACK_TOP) req_code = F_UNDER;
      OP_LOAD, OP_STORE: begin
        if (addr_misal)        req_code = F_ALIGN;
        else if (!addr_in_mem) req_code = F_RANGE;
      end
      OP_ADD: begin
        if (data_misal)         req_code = F_ALIGN;
        else if (!add_in_range) req_code = F_RANGE;
      end
      OP_SET: begin
        if (addr_misal)        req_code = F_ALIGN;
        else if (!addr_in_esp) req_code = F_RANGE;
      end
      OP_NOP:  req_code = F_NONE;
      default: req_code = F_ILLEG;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    op_ready     = 1'b0;
    esp_d        = esp_q;
    rd_idx_d     = rd_idx_q;
    mem_we       = 1'b0;
    mem_widx     = '0;
    fault_d      = fault_q;
    fault_code_d = fault_code_q;

    // Clear first so a fault in the same cycle latches its own code.
    if (clear_fault) begin
      fault_d      = 1'b0;
      fault_code_d = F_NONE;
    end

    case (state_q)
      S_IDLE: begin
        op_ready = 1'b1;
        if (op_valid) begin
          if (req_code != F_NONE) begin
            if (!fault_d) begin
              fault_d      = 1'b1;
              fault_code_d = req_code;
            end
          end else begin
            case (op_code)
              OP_PUSH: begin
                esp_d    = esp_q - BYTES32;
                mem_we   = 1'b1;
                mem_widx = push_idx;
              end
              OP_POP: begin
                rd_idx_d = esp_idx;
                esp_d    = esp_q + BYTES32;
                state_d  = S_READ;
              end
              OP_LOAD: begin
                rd_idx_d = addr_idx;
                state_d  = S_READ;
              end
              OP_STORE: begin
                mem_we   = 1'b1;
                mem_widx = addr_idx;
              end
              OP_ADD:  esp_d = add_sum[31:0];
              OP_SET:  esp_d = op_addr;
              default: ;
            endcase
          end
        end
      end
      S_READ:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      esp_q        <= STACK_TOP;
      fault_q      <= 1'b0;
      fault_code_q <= F_NONE;
      rd_data_q    <= '0;
      rd_valid_q   <= 1'b0;
      rd_idx_q     <= '0;
    end else begin
      state_q      <= state_d;
      esp_q        <= esp_d;
      fault_q      <= fault_d;
      fault_code_q <= fault_code_d;
      rd_idx_q     <= rd_idx_d;
      rd_valid_q   <= (state_q == S_READ);
      if (state_q == S_READ) rd_data_q <= mem[rd_idx_q];
    end
  end

  // Contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_widx] <= op_data;
  end

  assign esp        = esp_q;
  assign count      = CW'((STACK_TOP - esp_q) >> LB);
  assign full       = (esp_q == BASE);
  assign empty      = (esp_q == STACK_TOP);
  assign fault      = fault_q;
  assign fault_code = fault_code_q;
  assign rd_data    = rd_data_q;
  assign rd_valid   = rd_valid_q;

endmodule
